// File: rtl/mmio_bridge.sv
// mmio_bridge: routes the core's byte-serial bus to the 128 KB RAM or to the I/O block
// (UART RX/TX with a TX FIFO, cycle counter snapshot and the program-stop sequence).
module mmio_bridge #(
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        tx_overflow,
    output logic        halt
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     cnt;
    logic [31:0]     cnt_snap;
    logic [7:0]      rx_q;
    logic [3:0]      sel_q;
    logic [7:0]      fifo_mem [TX_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;

    logic       io;
    logic       act;
    logic [2:0] offset;
    logic       rx_rd;
    logic       snap_rd;
    logic       stop_wr;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       unused_addr_bits;

    assign io       = (cpu_a[17:16] == 2'b11);
    assign act      = rdy_in & (state != HALT);
    assign offset   = cpu_a[2:0];
    assign unused_addr_bits = ^cpu_a[31:18];

    assign ram_a    = cpu_a[16:0];
    assign ram_din  = cpu_dout;
    assign ram_we   = cpu_wr & ~io & rdy_in;

    // RX pops and TX pushes are only legal while running; snapshots stay live during drain.
    assign rx_rd    = act & io & ~cpu_wr & (offset == 3'd0) & (state == RUN);
    assign snap_rd  = act & io & ~cpu_wr & (offset == 3'd4);
    assign stop_wr  = act & io & cpu_wr & (offset == 3'd4) & (state == RUN);
    assign push_req = act & io & cpu_wr & (offset == 3'd0) & (cpu_dout != 8'h00) & (state == RUN);

    assign tx_valid = (count != '0);
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign pop      = tx_valid & tx_ready;
    assign push     = push_req & ((count < CW'(TX_DEPTH)) | pop);
    assign rx_pop   = rx_rd & rx_valid & ~rst_in;
    assign halt     = (state == HALT);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (stop_wr) state_next = (count == '0) ? HALT : DRAIN;
            DRAIN:   if (count == '0) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        cpu_din = 8'h00;
        if (!sel_q[3]) begin
            cpu_din = ram_dout;
        end else begin
            case (sel_q[2:0])
                3'd0:    cpu_din = rx_q;
                3'd4:    cpu_din = cnt_snap[7:0];
                3'd5:    cpu_din = cnt_snap[15:8];
                3'd6:    cpu_din = cnt_snap[23:16];
                3'd7:    cpu_din = cnt_snap[31:24];
                default: cpu_din = 8'h00;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= RUN;
            cnt            <= '0;
            cnt_snap       <= '0;
            rx_q           <= 8'h00;
            sel_q          <= 4'h0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            state <= state_next;
            if (act) cnt <= cnt + 32'd1;
            if (rdy_in) sel_q <= {io, offset};
            if (snap_rd) cnt_snap <= cnt;
            if (rx_rd) rx_q <= rx_valid ? rx_data : 8'h00;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count          <= count_next;
            io_buffer_full <= (count_next >= CW'(TX_DEPTH - FULL_MARGIN));
            if (push_req && !push) tx_overflow <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy is tracked by count and tx_data is masked when empty.
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr] <= cpu_dout;
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge: read-data and TX-byte scoreboards
// plus a cycle-counter model, checked with immediate assertions.
module tb_mmio_bridge;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout = 8'h00;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_overflow;
    logic        halt;

    typedef struct {
        int          due;
        logic [7:0]  val;
        logic [31:0] addr;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_exp[$];
    logic [7:0] ram_mem [0:131071];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mcnt = 0;
    int halt_due = 32'h7fff_ffff;
    int last_pop_cyc = 0;
    int rx_pops = 0;
    int ram_wes = 0;
    int base;
    logic [31:0] snap;

    mmio_bridge #(.TX_DEPTH(8), .FULL_MARGIN(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full),
        .ram_a(ram_a), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_overflow(tx_overflow), .halt(halt)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;
    end

    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_din;
        ram_dout <= ram_mem[ram_a];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: sample outputs on the falling edge, update the counter model on the rising edge.
    task automatic step();
        rd_exp_t e;
        @(negedge clk_in);
        if (tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) begin
                check("tx_unexpected_pop", tx_exp.size(), 1);
            end else begin
                check("tx_data", {24'h0, tx_data}, {24'h0, tx_exp.pop_front()});
                last_pop_cyc = cyc;
            end
        end
        while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            e = rd_q.pop_front();
            check($sformatf("cpu_din@%0h", e.addr), {24'h0, cpu_din}, {24'h0, e.val});
        end
        if (rx_pop) rx_pops++;
        if (ram_we) ram_wes++;
        @(posedge clk_in);
        if (rst_in) begin
            mcnt = 0;
            halt_due = 32'h7fff_ffff;
        end else if (rdy_in && cyc < halt_due) begin
            mcnt++;
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cpu_a = a; cpu_wr = 1'b1; cpu_dout = d; rdy_in = 1'b1;
        step();
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] e);
        cpu_a = a; cpu_wr = 1'b0; cpu_dout = 8'h00; rdy_in = 1'b1;
        rd_q.push_back('{due: cyc + 1, val: e, addr: a});
        step();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; cpu_a = 32'h0; cpu_dout = 8'h00; cpu_wr = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        #1;
        repeat (3) step();

        // Reset state
        check("rst_cpu_din", {24'h0, cpu_din}, 32'h0);
        check("rst_rx_pop", {31'h0, rx_pop}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_overflow", {31'h0, tx_overflow}, 32'h0);
        check("rst_halt", {31'h0, halt}, 32'h0);
        check("rst_full", {31'h0, io_buffer_full}, 32'h0);
        check("rst_cnt", dut.cnt, 32'h0);
        rst_in = 1'b0; rdy_in = 1'b1;

        // RAM write then read, plus the top RAM address
        base = ram_wes;
        wr(32'h0000_0123, 8'h5A);
        rd(32'h0000_0123, 8'h5A);
        idle();
        check("ram_we_once", ram_wes - base, 1);
        wr(32'h0001_FFFF, 8'hA5);
        rd(32'h0001_FFFF, 8'hA5);
        idle();

        // TX sequence with zero-byte filtering
        tx_ready = 1'b1;
        tx_exp.push_back(8'h41); wr(32'h0003_0000, 8'h41);
        tx_exp.push_back(8'h42); wr(32'h0003_0000, 8'h42);
        wr(32'h0003_0000, 8'h00);
        tx_exp.push_back(8'h43); wr(32'h0003_0000, 8'h43);
        repeat (4) idle();
        check("tx_seq_drained", tx_exp.size(), 0);

        // Fill, overflow, push-with-pop on full, drain in order
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_exp.push_back(8'h10 + 8'(i));
            wr(32'h0003_0000, 8'h10 + 8'(i));
            check($sformatf("full_after_%0d", i + 1), {31'h0, io_buffer_full}, (i + 1 >= 6) ? 1 : 0);
        end
        check("no_overflow_yet", {31'h0, tx_overflow}, 32'h0);
        wr(32'h0003_0000, 8'h99);
        check("overflow_set", {31'h0, tx_overflow}, 32'h1);
        check("count_stays_8", 32'(dut.count), 32'd8);
        tx_ready = 1'b1;
        tx_exp.push_back(8'hAA);
        wr(32'h0003_0000, 8'hAA);
        check("full_push_pop_count", 32'(dut.count), 32'd8);
        for (int i = 0; i < 16 && tx_exp.size() > 0; i++) idle();
        idle();
        check("fill_drained", tx_exp.size(), 0);
        check("fill_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("fill_full_clear", {31'h0, io_buffer_full}, 32'h0);

        // Counter snapshot after 100 ready cycles, then rdy_in low for 10 cycles
        rst_in = 1'b1;
        repeat (2) idle();
        rst_in = 1'b0;
        check("ovf_cleared", {31'h0, tx_overflow}, 32'h0);
        rdy_in = 1'b1;
        repeat (100) idle();
        snap = 32'(mcnt);
        check("model_cnt_100", snap, 32'd100);
        rd(32'h0003_0004, snap[7:0]);
        rd(32'h0003_0005, snap[15:8]);
        rd(32'h0003_0006, snap[23:16]);
        rd(32'h0003_0007, snap[31:24]);
        idle();
        rdy_in = 1'b0;
        repeat (10) idle();
        check("cnt_paused", dut.cnt, 32'(mcnt));
        rdy_in = 1'b1;
        snap = 32'(mcnt);
        rd(32'h0003_0004, snap[7:0]);
        rd(32'h0003_0005, snap[15:8]);
        idle();

        // RX read with and without data, other I/O offset reads zero
        base = rx_pops;
        rx_valid = 1'b1; rx_data = 8'h37;
        rd(32'h0003_0000, 8'h37);
        rx_valid = 1'b0;
        idle();
        check("rx_pop_once", rx_pops - base, 1);
        base = rx_pops;
        rd(32'h0003_0000, 8'h00);
        idle();
        check("rx_no_pop", rx_pops - base, 0);
        rd(32'h0003_0002, 8'h00);
        idle();

        // Stop sequence: queue, stop, ignored writes/RX, drain, halt, freeze, reset
        tx_ready = 1'b0;
        tx_exp.push_back(8'h61); wr(32'h0003_0000, 8'h61);
        tx_exp.push_back(8'h62); wr(32'h0003_0000, 8'h62);
        tx_exp.push_back(8'h63); wr(32'h0003_0000, 8'h63);
        wr(32'h0003_0004, 8'h01);
        check("state_drain", 32'(dut.state), 32'd1);
        check("drain_halt_low", {31'h0, halt}, 32'h0);
        wr(32'h0003_0000, 8'h77);
        check("drain_push_ignored", 32'(dut.count), 32'd3);
        base = rx_pops;
        rx_valid = 1'b1; rx_data = 8'h55;
        rd(32'h0003_0000, 8'h00);
        rx_valid = 1'b0;
        idle();
        check("drain_no_rx_pop", rx_pops - base, 0);
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && tx_exp.size() > 0; i++) idle();
        check("drain_done", tx_exp.size(), 0);
        halt_due = last_pop_cyc + 2;
        check("halt_not_yet", {31'h0, halt}, 32'h0);
        idle();
        check("halt_set", {31'h0, halt}, 32'h1);
        check("cnt_at_halt", dut.cnt, 32'(mcnt));
        repeat (10) idle();
        check("cnt_frozen", dut.cnt, 32'(mcnt));
        wr(32'h0000_0200, 8'hC3);
        rd(32'h0000_0200, 8'hC3);
        wr(32'h0003_0000, 8'h55);
        check("halt_no_push", {31'h0, tx_valid}, 32'h0);
        idle();
        rst_in = 1'b1;
        idle();
        rst_in = 1'b0;
        check("halt_cleared", {31'h0, halt}, 32'h0);
        check("cnt_reset", dut.cnt, 32'h0);
        check("state_run", 32'(dut.state), 32'd0);
        idle();
        check("rd_scoreboard_empty", rd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits directly downstream of the CPU core's byte-serial memory bus (address, data out, write strobe, data in, io_buffer_full).
- Routes each bus access either to the 128 KB RAM or to the I/O region (addr[17:16]==2'b11).
- Implements the I/O side: UART RX read, buffered UART TX with backpressure, the cycle counter at 0x30004 and the program-stop sequence.
- Returns read data to the core with the fixed one-cycle read latency.

Parameters:
TX_DEPTH, 8, TX FIFO entries (power of two, >=4)
FULL_MARGIN, 2, free-slot margin at which io_buffer_full asserts

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  core ready; low = core paused, core-originated actions ignored
cpu_a  in  32  core address (only 17:0 decoded)
cpu_dout  in  8  core write data
cpu_wr  in  1  1 = write, 0 = read
cpu_din  out  8  read data to core, valid the cycle after the read address
io_buffer_full  out  1  TX backpressure to core
ram_a  out  17  RAM address = cpu_a[16:0]
ram_din  out  8  RAM write data = cpu_dout
ram_we  out  1  RAM write enable
ram_dout  in  8  RAM read data, one cycle after ram_a
rx_valid  in  1  UART RX byte available
rx_data  in  8  UART RX byte
rx_pop  out  1  one-cycle pulse consuming rx_data
tx_valid  out  1  TX FIFO non-empty
tx_data  out  8  TX FIFO head
tx_ready  in  1  UART TX accepts head this cycle
tx_overflow  out  1  sticky: a push was dropped on a full FIFO
halt  out  1  sticky: program stopped and TX drained

Behaviour:
- io = (cpu_a[17:16]==2'b11). act = rdy_in & ~halt_state.
- RAM path is combinational: ram_a = cpu_a[16:0], ram_din = cpu_dout, ram_we = cpu_wr & ~io & rdy_in.
- Read select register sel_q = {io, cpu_a[2:0]}, captured every cycle rdy_in=1; holds otherwise.
- cpu_din mux on sel_q:
  - RAM: ram_dout.
  - offset 0: rx_q.
  - offsets 4..7: byte (offset-4) of cnt_snap (little-endian).
  - other I/O offsets: 8'h00.
- RX read (act, io, read, offset 0):
  - rx_valid=1: rx_q <= rx_data and rx_pop pulses that cycle.
  - rx_valid=0: rx_q <= 8'h00, no pop.
- Counter: cnt 32-bit, reset 0, +1 each cycle rdy_in=1 and state!=HALT, wraps 0xFFFFFFFF->0.
- Counter snapshot: io read at offset 4 with act: cnt_snap <= cnt (current value). Offsets 5..7 do not resnapshot, so a 4-byte read is coherent.
- TX FIFO:
  - push = act & io & cpu_wr & offset 0 & cpu_dout!=0 & state==RUN. Writes of 0x00 are ignored.
  - pop = tx_valid & tx_ready. Popping is independent of rdy_in and continues in DRAIN.
  - Push is accepted when count<TX_DEPTH or pop is asserted in the same cycle. Otherwise the byte is dropped and tx_overflow <= 1.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo TX_DEPTH.
  - io_buffer_full = (count >= TX_DEPTH-FULL_MARGIN), registered from next-state count.
- Stop FSM:
  - RUN: a write (act) to io offset 4 moves to DRAIN.
  - DRAIN: no further pushes or RX pops. When count==0 and no push is pending, move to HALT.
  - HALT: halt=1, cnt frozen, all bus actions ignored except RAM writes gated only by rdy_in. Leaves HALT only on reset.
  - A stop write while the FIFO is empty reaches HALT on the next cycle.
- Reset values: cpu_din 0, rx_pop 0, tx_valid 0, tx_data don't-care (0 in sim), tx_overflow 0, halt 0, io_buffer_full 0, cnt 0, cnt_snap 0, rx_q 0, sel_q 0, state RUN, FIFO empty.
- Reset mid-operation flushes the FIFO and drops any pending stop.

Test Plan:
- RAM write a=0x00123 d=0x5A, then read a=0x00123 -> ram_we=1 for exactly one cycle; cpu_din=0x5A on the cycle after the read.
- Write bytes 0x41,0x42,0x00,0x43 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41,0x42,0x43; 0x00 never appears.
- tx_ready=0, write 8 bytes (TX_DEPTH=8) -> io_buffer_full=1 once count>=6; 9th write sets tx_overflow=1 and count stays 8. tx_ready=1 then drains 8 bytes in order.
- Reset, then after 100 rdy cycles read 0x30004..0x30007 on consecutive cycles -> bytes form snapshot 100 (0x64,0,0,0). rdy_in held low 10 cycles does not advance cnt.
- Read 0x30000 with rx_valid=1, rx_data=0x37 -> rx_pop pulses once and cpu_din=0x37 next cycle. With rx_valid=0 -> cpu_din=0x00 and no pop.
- Queue 3 bytes with tx_ready=0, write 0x30004 -> state DRAIN, halt=0. Further writes to 0x30000 are ignored. tx_ready=1 drains 3 bytes, then halt=1 one cycle after empty and cnt freezes. rst_in clears halt.
